// File: rtl/snake_pkg.sv
// Shared constants for the snake game front end: PS/2 scan codes,
// keystroke bit positions, RX FSM states and the key lookup helper.
package snake_pkg;

  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_CLR   = 8'h2D;
  localparam logic [7:0] SC_PAUSE = 8'h4D;
  localparam logic [7:0] SC_FAST  = 8'h55;
  localparam logic [7:0] SC_SLOW  = 8'h4E;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  localparam int KS_L1 = 0, KS_R1 = 1, KS_UP1 = 2, KS_DN1 = 3;
  localparam int KS_L2 = 4, KS_R2 = 5, KS_UP2 = 6, KS_DN2 = 7;
  localparam int KS_CLR = 8, KS_PAUSE = 9, KS_FAST = 10, KS_SLOW = 11;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_hit_t;

  // Keyboard housekeeping replies (BAT, ACK, echo, resend, errors)
  function automatic logic is_ignored(input logic [7:0] c);
    return c inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction

  function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] c);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = 4'd0;
    if (ext) begin
      case (c)
        SC_LEFT:  r.idx = 4'(KS_L2);
        SC_RIGHT: r.idx = 4'(KS_R2);
        SC_UP:    r.idx = 4'(KS_UP2);
        SC_DOWN:  r.idx = 4'(KS_DN2);
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (c)
        SC_A:     r.idx = 4'(KS_L1);
        SC_D:     r.idx = 4'(KS_R1);
        SC_W:     r.idx = 4'(KS_UP1);
        SC_S:     r.idx = 4'(KS_DN1);
        SC_CLR:   r.idx = 4'(KS_CLR);
        SC_PAUSE: r.idx = 4'(KS_PAUSE);
        SC_FAST:  r.idx = 4'(KS_FAST);
        SC_SLOW:  r.idx = 4'(KS_SLOW);
        default:  r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: input sync, clock deglitch filter,
// start/data/parity/stop FSM and inactivity timeout.
module ps2_rx
  import snake_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    ck_sync_q, dt_sync_q;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          filt_q, filt_d, filt_prev_q;
  logic [TW-1:0] tmo_q, tmo_d;
  rx_state_e     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_ok_q, par_ok_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic          ck_s, din, fall, tmo_hit;

  assign ck_s = ck_sync_q[1];
  assign din  = dt_sync_q[1];
  assign fall = filt_prev_q & ~filt_q;

  // Level only follows the synced clock after FILTER_LEN differing samples in a row
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (ck_s != filt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = ck_s;
      else flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q != RX_IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign tmo_d   = (state_q == RX_IDLE || fall) ? '0 : tmo_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_sync_q   <= 2'b11;
      dt_sync_q   <= 2'b11;
      flt_cnt_q   <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      tmo_q       <= '0;
      state_q     <= RX_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_ok_q    <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ck_sync_q   <= {ck_sync_q[0], ps2_clk};
      dt_sync_q   <= {dt_sync_q[0], ps2_data};
      flt_cnt_q   <= flt_cnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      tmo_q       <= tmo_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_ok_q    <= par_ok_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tmo_hit) state_d = RX_IDLE;
    else if (fall) begin
      case (state_q)
        RX_IDLE:   if (!din) state_d = RX_DATA;
        RX_DATA:   if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        RX_PARITY: state_d = RX_STOP;
        RX_STOP:   state_d = RX_IDLE;
        default:   state_d = RX_IDLE;
      endcase
    end
  end

  // Parity verdict is held until the stop sample so a bad frame gives one error pulse
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_ok_d  = par_ok_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (tmo_hit) err_d = 1'b1;
    else if (fall) begin
      case (state_q)
        RX_IDLE:   bit_cnt_d = '0;
        RX_DATA:   begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        RX_PARITY: par_ok_d = ^{shift_q, din};
        RX_STOP:   if (din && par_ok_q) valid_d = 1'b1; else err_d = 1'b1;
        default:   ;
      endcase
    end
  end

  assign rx_byte  = shift_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;

endmodule

// File: rtl/ps2_keystroke.sv
// Scan-code parser: tracks E0/F0 prefixes, held direction keys and
// one-shot control keys, producing the 16-bit keystroke vector.
module ps2_keystroke
  import snake_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keystroke,
  output logic        frame_err
);
  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic [7:0] dir_q, dir_d;
  logic [3:0] held_q, held_d, pulse_q, pulse_d;
  key_hit_t   hit;

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  assign hit = key_lookup(ext_q, rx_byte);

  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    dir_d   = dir_q;
    held_d  = held_q;
    pulse_d = '0;
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_EXT) ext_d = 1'b1;
      else if (rx_byte == SC_BRK) brk_d = 1'b1;
      else if (!is_ignored(rx_byte)) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (hit.hit) begin
          // Control keys fire once per press; typematic repeats are swallowed
          if (hit.idx[3]) begin
            if (brk_q) held_d[hit.idx[1:0]] = 1'b0;
            else if (!held_q[hit.idx[1:0]]) begin
              held_d[hit.idx[1:0]]  = 1'b1;
              pulse_d[hit.idx[1:0]] = 1'b1;
            end
          end else begin
            dir_d[hit.idx[2:0]] = ~brk_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      dir_q   <= '0;
      held_q  <= '0;
      pulse_q <= '0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      dir_q   <= dir_d;
      held_q  <= held_d;
      pulse_q <= pulse_d;
    end
  end

  assign keystroke = {4'b0000, pulse_q, dir_q};
  assign frame_err = rx_err;

endmodule
